clk_switch_ctrl: RTL

Controller that drives the select line of the board clock multiplexer (BUFGMUX S pin) choosing between clk_100m and clk_125m, and checks that the muxed clock tree actually runs after each switch. It runs on the free-running clk_100m, holds logic on the muxed tree quiescent across the switch, and monitors a heartbeat bit from a counter clocked by the muxed tree. On a dead clock it reverts the select and flags a failure.

---
 rtl/clk_switch_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/clk_switch_ctrl.sv
// Clock-select controller for a BUFGMUX: quiesces the muxed tree,
// switches, then proves the new clock runs via a heartbeat bit.
//
// Ports:
//   clk_100m    free-running controller clock (not the muxed clock)
//   reset_n     async active-low reset
//   sel_req     requested select level (clk_100m domain)
//   fail_clr    one-cycle pulse, clears ck_fail
//   heartbeat   async counter bit from the muxed domain
//   ck_sel      registered select to the BUFGMUX S pin
//   hold_n      low while muxed-domain logic must hold state
//   busy        high while a switch is in progress
//   switch_done one-cycle pulse when a switch passes its check
//   ck_fail     sticky failure flag
module clk_switch_ctrl #(
  parameter bit SEL_RST    = 1'b0,
  parameter int HOLD_CYC   = 16,
  parameter int SETTLE_CYC = 32,
  parameter int WIN_CYC    = 256,
  parameter int MIN_EDGES  = 8
) (
  input  logic clk_100m,
  input  logic reset_n,
  input  logic sel_req,
  input  logic fail_clr,
  input  logic heartbeat,
  output logic ck_sel,
  output logic hold_n,
  output logic busy,
  output logic switch_done,
  output logic ck_fail
);

  typedef enum logic [2:0] {
    IDLE,
    QUIESCE,
    SWITCH,
    SETTLE,
    CHECK,
    REVERT
  } state_t;

  localparam logic [15:0] HOLD_LD = 16'(HOLD_CYC - 1);
  localparam logic [15:0] SETL_LD = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] WIN_LD  = 16'(WIN_CYC - 1);
  localparam logic [7:0]  MIN_E   = 8'(MIN_EDGES);

  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic [7:0]  edges, edges_nx, edges_tot;
  logic        hb_s1, hb_s2, hb_s3, primed;
  logic        edge_hit, cnt_zero, pass;
  logic        tgt, tgt_nx;
  logic        fail_tgt, fail_tgt_nx;
  logic        rechk, rechk_nx;
  logic        sel_nx, fail_nx, done_nx;

  // primed masks the first cycle out of reset
  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) begin
      hb_s1  <= 1'b0;
      hb_s2  <= 1'b0;
      hb_s3  <= 1'b0;
      primed <= 1'b0;
    end else begin
      hb_s1  <= heartbeat;
      hb_s2  <= hb_s1;
      hb_s3  <= hb_s2;
      primed <= 1'b1;
    end
  end

  assign edge_hit = primed & (hb_s2 ^ hb_s3);

  // saturating count including this cycle's edge
  assign edges_tot = (edges == 8'hFF) ? 8'hFF
                   : edges + {7'd0, edge_hit};
  assign pass     = (edges_tot >= MIN_E);
  assign cnt_zero = (cnt == 16'd0);

  assign hold_n = (state == IDLE);
  assign busy   = (state != IDLE);

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    edges_nx    = edges;
    tgt_nx      = tgt;
    fail_tgt_nx = fail_tgt;
    rechk_nx    = rechk;
    sel_nx      = ck_sel;
    fail_nx     = fail_clr ? 1'b0 : ck_fail;
    done_nx     = 1'b0;
    unique case (state)
      IDLE: begin
        if (sel_req != ck_sel &&
            !(ck_fail && sel_req == fail_tgt)) begin
          tgt_nx   = sel_req;
          rechk_nx = 1'b0;
          cnt_nx   = HOLD_LD;
          state_nx = QUIESCE;
        end
      end
      QUIESCE: begin
        if (cnt_zero) begin
          sel_nx   = tgt;
          state_nx = SWITCH;
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      SWITCH: begin
        cnt_nx   = SETL_LD;
        state_nx = SETTLE;
      end
      SETTLE: begin
        if (cnt_zero) begin
          cnt_nx   = WIN_LD;
          edges_nx = 8'd0;
          state_nx = CHECK;
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      CHECK: begin
        edges_nx = edges_tot;
        if (!cnt_zero) begin
          cnt_nx = cnt - 16'd1;
        end else if (pass) begin
          // a passing re-check only confirms the old clock
          done_nx  = !rechk;
          state_nx = IDLE;
        end else if (!rechk) begin
          sel_nx      = ~tgt;
          fail_nx     = 1'b1;
          fail_tgt_nx = tgt;
          state_nx    = REVERT;
        end else begin
          fail_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      REVERT: begin
        rechk_nx = 1'b1;
        cnt_nx   = SETL_LD;
        state_nx = SETTLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= 16'd0;
      edges       <= 8'd0;
      tgt         <= 1'b0;
      fail_tgt    <= 1'b0;
      rechk       <= 1'b0;
      ck_sel      <= SEL_RST;
      ck_fail     <= 1'b0;
      switch_done <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      edges       <= edges_nx;
      tgt         <= tgt_nx;
      fail_tgt    <= fail_tgt_nx;
      rechk       <= rechk_nx;
      ck_sel      <= sel_nx;
      ck_fail     <= fail_nx;
      switch_done <= done_nx;
    end
  end

endmodule
